// File: rtl/sprite_line_eval.sv
// sprite_line_eval
//   Per-scanline sprite evaluator. On each line_start the back buffer is
//   swapped to the front buffer (slot_data/slot_valid/overflow), and a new
//   scan of sprite RAM starts for next_line_y. Sprites covering that line
//   fill the back buffer slots in RAM order (slot 0 = lowest RAM index =
//   highest priority).
//
//   Optional feature macro: SPRITE_OVERFLOW_EN
//     defined   : hits beyond SLOT_NUM raise overflow for the displayed line,
//                 and the scan always covers the whole RAM.
//     undefined : overflow is tied 0 and the scan stops once all slots fill.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high (overrides line_start)
//   line_start   1-cycle pulse: swap buffers, start scan for next_line_y
//   next_line_y  line to be evaluated, sampled on line_start
//   ram_addr     sprite RAM read address
//   ram_data     sprite RAM read data, valid one cycle after ram_addr
//   slot_data    front-buffer sprite words, slot k at [k*DATA_W +: DATA_W]
//   slot_valid   front-buffer slot occupied flags
//   eval_busy    scan in progress (SCAN or DRAIN)
//   eval_done    1-cycle pulse when the back buffer is complete
//   overflow     more than SLOT_NUM sprites hit the displayed line
module sprite_line_eval #(
    parameter int SLOT_NUM   = 8,
    parameter int SPRITE_NUM = 64,
    parameter int ADDR_W     = $clog2(SPRITE_NUM),
    parameter int DATA_W     = 32,
    parameter int POSY_W     = 10,
    parameter int Y_LSB      = 16,
    parameter int SPRITE_H   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       line_start,
    input  logic [POSY_W-1:0]          next_line_y,
    output logic [ADDR_W-1:0]          ram_addr,
    input  logic [DATA_W-1:0]          ram_data,
    output logic [SLOT_NUM*DATA_W-1:0] slot_data,
    output logic [SLOT_NUM-1:0]        slot_valid,
    output logic                       eval_busy,
    output logic                       eval_done,
    output logic                       overflow
);

    localparam int CNT_W = $clog2(SLOT_NUM + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t              state, state_next;
    logic [POSY_W-1:0]   line_q;
    logic [CNT_W-1:0]    slot_cnt;
    logic                vld_p0;
    logic [DATA_W-1:0]   back_data [SLOT_NUM];
    logic [SLOT_NUM-1:0] back_valid;
    logic                slots_full;
    logic                addr_last;
    logic                scan_last;
    logic                hit_p0;

    // Unsigned wrap makes sprites starting below the line a miss, while
    // sprites hanging above line 0 (y near 2^POSY_W) still cover it.
    function automatic logic is_hit(input logic [POSY_W-1:0] line,
                                    input logic [DATA_W-1:0] word);
        logic [POSY_W-1:0] diff;
        diff = line - word[Y_LSB +: POSY_W];
        return diff < POSY_W'(SPRITE_H);
    endfunction

    assign slots_full = (slot_cnt == CNT_W'(SLOT_NUM));
    assign addr_last  = (ram_addr == ADDR_W'(SPRITE_NUM - 1));
`ifdef SPRITE_OVERFLOW_EN
    assign scan_last  = addr_last;
`else
    assign scan_last  = addr_last || slots_full;
`endif

    // Stage p0: RAM word for the address issued last cycle
    assign hit_p0 = vld_p0 && is_hit(line_q, ram_data);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        eval_busy  = 1'b0;
        eval_done  = 1'b0;
        case (state)
            IDLE:  ;
            SCAN:  begin
                eval_busy = 1'b1;
                if (scan_last) state_next = DRAIN;
            end
            DRAIN: begin
                eval_busy  = 1'b1;
                state_next = DONE;
            end
            DONE:  begin
                eval_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (line_start) state_next = SCAN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q     <= '0;
            slot_cnt   <= '0;
            ram_addr   <= '0;
            vld_p0     <= 1'b0;
            back_valid <= '0;
            slot_valid <= '0;
            slot_data  <= '0;
            for (int k = 0; k < SLOT_NUM; k++) back_data[k] <= '0;
        end else if (line_start) begin
            // Swap wins over any hit pending this cycle; that hit is dropped.
            for (int k = 0; k < SLOT_NUM; k++)
                slot_data[k*DATA_W +: DATA_W] <= back_data[k];
            slot_valid <= back_valid;
            back_valid <= '0;
            line_q     <= next_line_y;
            slot_cnt   <= '0;
            ram_addr   <= '0;
            vld_p0     <= 1'b0;
        end else begin
            vld_p0 <= (state == SCAN);
            if (state == SCAN && !scan_last)
                ram_addr <= ram_addr + ADDR_W'(1);
            if (hit_p0 && !slots_full) begin
                for (int k = 0; k < SLOT_NUM; k++) begin
                    if (slot_cnt == CNT_W'(k)) begin
                        back_data[k]  <= ram_data;
                        back_valid[k] <= 1'b1;
                    end
                end
                slot_cnt <= slot_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SPRITE_OVERFLOW_EN
    logic back_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            back_ovf <= 1'b0;
            overflow <= 1'b0;
        end else if (line_start) begin
            overflow <= back_ovf;
            back_ovf <= 1'b0;
        end else if (hit_p0 && slots_full) begin
            back_ovf <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_line_eval.sv
// tb_sprite_line_eval
//   Directed bench for sprite_line_eval: a default-parameter instance
//   (8 slots, 64 sprites) and a wide instance (16 slots, 128 sprites), each
//   fed by a synchronous sprite RAM model with one cycle read latency.
module tb_sprite_line_eval;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         line_start, line_start2;
    logic [9:0]   next_line_y, next_line_y2;
    logic [5:0]   ram_addr;
    logic [6:0]   ram_addr2;
    logic [31:0]  ram_data, ram_data2;
    logic [255:0] slot_data;
    logic [511:0] slot_data2;
    logic [7:0]   slot_valid;
    logic [15:0]  slot_valid2;
    logic         eval_busy, eval_done, overflow;
    logic         eval_busy2, eval_done2, overflow2;

    logic [31:0] mem  [64];
    logic [31:0] mem2 [128];

    always_ff @(posedge clk) ram_data  <= mem[ram_addr];
    always_ff @(posedge clk) ram_data2 <= mem2[ram_addr2];

    sprite_line_eval u_dut (
        .clk(clk), .rst(rst), .line_start(line_start), .next_line_y(next_line_y),
        .ram_addr(ram_addr), .ram_data(ram_data), .slot_data(slot_data),
        .slot_valid(slot_valid), .eval_busy(eval_busy), .eval_done(eval_done),
        .overflow(overflow)
    );

    sprite_line_eval #(.SLOT_NUM(16), .SPRITE_NUM(128)) u_big (
        .clk(clk), .rst(rst), .line_start(line_start2), .next_line_y(next_line_y2),
        .ram_addr(ram_addr2), .ram_data(ram_data2), .slot_data(slot_data2),
        .slot_valid(slot_valid2), .eval_busy(eval_busy2), .eval_done(eval_done2),
        .overflow(overflow2)
    );

    int errors = 0;
    int checks = 0;

`ifdef SPRITE_OVERFLOW_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    function automatic logic [31:0] mk(input int y, input int idx);
        return {6'd0, 10'(y), 8'hA5, 8'(idx)};
    endfunction

    task automatic fill(input int y);
        for (int i = 0; i < 64; i++) mem[i] = mk(y, i);
    endtask

    // Pulse line_start; returns at the falling edge after it was sampled.
    task automatic pulse(input int y);
        @(negedge clk);
        line_start  = 1'b1;
        next_line_y = 10'(y);
        @(negedge clk);
        line_start  = 1'b0;
    endtask

    // Count falling edges from the line_start edge until eval_done is seen.
    task automatic run_scan(input int y, output int lat);
        pulse(y);
        lat = 1;
        while (eval_done !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        line_start = 1'b1;
        next_line_y = 10'd5;
        repeat (2) @(negedge clk);
        checks++; if (slot_valid !== 8'h00) begin errors++; $display("FAIL rst_valid: got %h expected 00", slot_valid); end
        checks++; if (slot_data !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", slot_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
        checks++; if (eval_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", eval_busy); end
        checks++; if (ram_addr !== 6'd0) begin errors++; $display("FAIL rst_addr: got %0d expected 0", ram_addr); end
        rst = 1'b0;
        line_start = 1'b0;
        @(negedge clk);
        checks++; if (eval_busy !== 1'b0) begin errors++; $display("FAIL rst_over_ls: busy got %b expected 0", eval_busy); end
    endtask

    task automatic test_one_hit;
        int lat;
        fill(600);
        mem[5] = mk(100, 5);
        run_scan(105, lat);
        checks++; if (lat != 66) begin errors++; $display("FAIL one_hit_lat: got %0d expected 66", lat); end
        checks++; if (ram_addr !== 6'd63) begin errors++; $display("FAIL one_hit_addr_hold: got %0d expected 63", ram_addr); end
        checks++; if (eval_busy !== 1'b0) begin errors++; $display("FAIL one_hit_busy: got %b expected 0", eval_busy); end
        pulse(105);
        checks++; if (slot_valid !== 8'h01) begin errors++; $display("FAIL one_hit_valid: got %h expected 01", slot_valid); end
        checks++; if (slot_data[31:0] !== mk(100, 5)) begin errors++; $display("FAIL one_hit_slot0: got %h expected %h", slot_data[31:0], mk(100, 5)); end
        checks++; if (eval_busy !== 1'b1) begin errors++; $display("FAIL one_hit_busy2: got %b expected 1", eval_busy); end
    endtask

    task automatic test_boundaries;
        int lines [5] = '{100, 115, 116, 99, 3};
        logic [7:0] exp_v [5] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h01};
        int exp_i [5] = '{0, 0, 0, 0, 1};
        int exp_y [5] = '{100, 100, 0, 0, 1020};
        int lat;
        fill(600);
        mem[0] = mk(100, 0);
        mem[1] = mk(1020, 1);
        for (int t = 0; t < 5; t++) begin
            run_scan(lines[t], lat);
            pulse(lines[t]);
            checks++;
            if (slot_valid !== exp_v[t]) begin
                errors++; $display("FAIL bound_valid_line%0d: got %h expected %h", lines[t], slot_valid, exp_v[t]);
            end
            if (exp_v[t] != 8'h00) begin
                checks++;
                if (slot_data[31:0] !== mk(exp_y[t], exp_i[t])) begin
                    errors++; $display("FAIL bound_slot0_line%0d: got %h expected %h", lines[t], slot_data[31:0], mk(exp_y[t], exp_i[t]));
                end
            end
        end
    endtask

    task automatic test_overflow;
        int lat;
        int exp_lat;
        exp_lat = OVF_ON ? 66 : 12;
        fill(600);
        for (int i = 0; i < 10; i++) mem[i] = mk(50, i);
        run_scan(50, lat);
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL ovf_lat: got %0d expected %0d", lat, exp_lat); end
        pulse(900);
        checks++; if (slot_valid !== 8'hFF) begin errors++; $display("FAIL ovf_valid: got %h expected FF", slot_valid); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (slot_data[k*32 +: 32] !== mk(50, k)) begin
                errors++; $display("FAIL ovf_slot%0d: got %h expected %h", k, slot_data[k*32 +: 32], mk(50, k));
            end
        end
        checks++; if (overflow !== OVF_ON) begin errors++; $display("FAIL ovf_flag: got %b expected %b", overflow, OVF_ON); end
        repeat (30) @(negedge clk);
        checks++; if (overflow !== OVF_ON) begin errors++; $display("FAIL ovf_hold: got %b expected %b", overflow, OVF_ON); end
        checks++; if (slot_valid !== 8'hFF) begin errors++; $display("FAIL ovf_valid_hold: got %h expected FF", slot_valid); end

        // Exactly SLOT_NUM hits: full, no overflow.
        mem[8] = mk(600, 8);
        mem[9] = mk(600, 9);
        run_scan(50, lat);
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL exact_lat: got %0d expected %0d", lat, exp_lat); end
        pulse(900);
        checks++; if (slot_valid !== 8'hFF) begin errors++; $display("FAIL exact_valid: got %h expected FF", slot_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL exact_ovf: got %b expected 0", overflow); end

        // Zero hits.
        run_scan(900, lat);
        pulse(900);
        checks++; if (slot_valid !== 8'h00) begin errors++; $display("FAIL zero_valid: got %h expected 00", slot_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL zero_ovf: got %b expected 0", overflow); end
    endtask

    task automatic test_abort;
        int lat;
        logic seen_done;
        int hit_idx [5] = '{3, 10, 17, 18, 25};
        fill(600);
        for (int i = 0; i < 5; i++) mem[hit_idx[i]] = mk(200, hit_idx[i]);
        pulse(200);
        seen_done = 1'b0;
        repeat (19) begin
            @(negedge clk);
            if (eval_done === 1'b1) seen_done = 1'b1;
        end
        // Second pulse is sampled 20 edges after the first; the idx 18
        // compare lands on that same edge and is dropped.
        line_start  = 1'b1;
        next_line_y = 10'd200;
        if (eval_done === 1'b1) seen_done = 1'b1;
        @(negedge clk);
        line_start  = 1'b0;
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", seen_done); end
        checks++; if (slot_valid !== 8'h07) begin errors++; $display("FAIL abort_valid: got %h expected 07", slot_valid); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (slot_data[k*32 +: 32] !== mk(200, hit_idx[k])) begin
                errors++; $display("FAIL abort_slot%0d: got %h expected %h", k, slot_data[k*32 +: 32], mk(200, hit_idx[k]));
            end
        end
        lat = 1;
        while (eval_done !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 66) begin errors++; $display("FAIL abort_second_lat: got %0d expected 66", lat); end
        pulse(900);
        checks++; if (slot_valid !== 8'h1F) begin errors++; $display("FAIL abort_full_valid: got %h expected 1F", slot_valid); end
        checks++; if (slot_data[3*32 +: 32] !== mk(200, 18)) begin errors++; $display("FAIL abort_full_slot3: got %h expected %h", slot_data[3*32 +: 32], mk(200, 18)); end
        checks++; if (slot_data[4*32 +: 32] !== mk(200, 25)) begin errors++; $display("FAIL abort_full_slot4: got %h expected %h", slot_data[4*32 +: 32], mk(200, 25)); end
    endtask

    task automatic test_params;
        int lat;
        int exp_lat;
        exp_lat = OVF_ON ? 130 : 125;
        for (int i = 0; i < 128; i++) mem2[i] = mk(600, i);
        for (int k = 0; k < 16; k++) mem2[8*k] = mk(300, 8*k);
        @(negedge clk);
        line_start2  = 1'b1;
        next_line_y2 = 10'd305;
        @(negedge clk);
        line_start2  = 1'b0;
        lat = 1;
        while (eval_done2 !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL big_lat: got %0d expected %0d", lat, exp_lat); end
        @(negedge clk);
        line_start2  = 1'b1;
        next_line_y2 = 10'd900;
        @(negedge clk);
        line_start2  = 1'b0;
        checks++; if (slot_valid2 !== 16'hFFFF) begin errors++; $display("FAIL big_valid: got %h expected FFFF", slot_valid2); end
        checks++; if (overflow2 !== 1'b0) begin errors++; $display("FAIL big_ovf: got %b expected 0", overflow2); end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (slot_data2[k*32 +: 32] !== mk(300, 8*k)) begin
                errors++; $display("FAIL big_slot%0d: got %h expected %h", k, slot_data2[k*32 +: 32], mk(300, 8*k));
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        line_start   = 1'b0;
        line_start2  = 1'b0;
        next_line_y  = '0;
        next_line_y2 = '0;
        fill(600);
        for (int i = 0; i < 128; i++) mem2[i] = mk(600, i);
        test_reset();
        test_one_hit();
        test_boundaries();
        test_overflow();
        test_abort();
        test_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
